jpeg_mcu_seq: RTL and testbench

Next-generation MCU/block sequencer for the baseline JPEG decoder. It tracks which component (Y/Cb/Cr) and which 8x8 block coordinate is being decoded for arbitrary luma sampling factors (1x1, 2x1, 1x2, 2x2 → 4:4:4, 4:2:2, 4:4:0, 4:2:0) and for monochrome. It detects end of image from image height instead of an external end flag, and flags padding blocks that lie outside the image. It sits between the Huffman/IDCT block stream and the output writer, and drives block ID and type.

---
 rtl/jpeg_mcu_seq_if.sv | 37 +++
 rtl/jpeg_mcu_seq.sv | 166 ++++++++++++++++
 tb/tb_jpeg_mcu_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_mcu_seq_if.sv
// Block-stream interface of the MCU sequencer: image config and
// end-of-block pulses in, current block descriptor and status flags out.
interface jpeg_mcu_seq_if #(
  parameter int DIM_W = 16
);
  logic               img_start_i;
  logic [DIM_W-1:0]   img_width_i;
  logic [DIM_W-1:0]   img_height_i;
  logic               img_mono_i;
  logic [1:0]         img_hs_i;
  logic [1:0]         img_vs_i;
  logic               end_of_block_i;
  logic [2*DIM_W-1:0] block_id_o;
  logic [1:0]         block_type_o;
  logic [DIM_W-1:0]   block_x_o;
  logic [DIM_W-1:0]   block_y_o;
  logic               block_valid_o;
  logic               mcu_done_o;
  logic               end_of_image_o;
  logic               overflow_o;

  // Sequencer side
  modport slave (
    input  img_start_i, img_width_i, img_height_i, img_mono_i,
           img_hs_i, img_vs_i, end_of_block_i,
    output block_id_o, block_type_o, block_x_o, block_y_o,
           block_valid_o, mcu_done_o, end_of_image_o, overflow_o
  );

  // Decoder / bench side
  modport master (
    output img_start_i, img_width_i, img_height_i, img_mono_i,
           img_hs_i, img_vs_i, end_of_block_i,
    input  block_id_o, block_type_o, block_x_o, block_y_o,
           block_valid_o, mcu_done_o, end_of_image_o, overflow_o
  );
endinterface

// File: rtl/jpeg_mcu_seq.sv
// JPEG MCU/block sequencer: walks Y sub-blocks, then Cb, Cr, per MCU, in
// raster MCU order; flags padding blocks and end of image from the height.
module jpeg_mcu_seq #(
  parameter int DIM_W    = 16,
  parameter int MAX_SAMP = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  jpeg_mcu_seq_if.slave bus
);

  typedef enum logic [1:0] {T_Y = 2'd0, T_CB = 2'd1, T_CR = 2'd2, T_EOF = 2'd3} btype_e;

  localparam logic [1:0]   MAX_S = 2'(MAX_SAMP);
  localparam logic [DIM_W:0] ADD7  = (DIM_W+1)'(7);
  localparam logic [DIM_W:0] ADD15 = (DIM_W+1)'(15);

  // Mono forces 1x1; out-of-range factors fall back to 1.
  function automatic logic [1:0] eff_samp(input logic [1:0] s, input logic mono);
    if (mono || s == 2'd0 || s > MAX_S) return 2'd1;
    return s;
  endfunction

  // ceil(dim / (8*samp)); an empty dimension still yields one MCU.
  function automatic logic [DIM_W-1:0] mcu_cnt(input logic [DIM_W-1:0] dim,
                                                input logic [1:0] samp);
    logic [DIM_W:0] sum;
    if (dim == '0) return DIM_W'(1);
    if (samp == 2'd2) sum = ({1'b0, dim} + ADD15) >> 4;
    else              sum = ({1'b0, dim} + ADD7) >> 3;
    return sum[DIM_W-1:0];
  endfunction

  logic [DIM_W-1:0] width_q, width_d, height_q, height_d;
  logic [DIM_W-1:0] mcus_x_q, mcus_x_d, mcus_y_q, mcus_y_d;
  logic [DIM_W-1:0] mcu_x_q, mcu_x_d, mcu_y_q, mcu_y_d;
  logic [DIM_W-1:0] bx_q, bx_d, by_q, by_d;
  logic [1:0]       hs_q, hs_d, vs_q, vs_d, sub_x_q, sub_x_d, sub_y_q, sub_y_d;
  logic             mono_q, mono_d;
  btype_e           type_q, type_d;
  logic             valid_q, valid_d, done_q, done_d, eoi_q, eoi_d, ovf_q, ovf_d;

  // scratch for the next-block walk
  logic [DIM_W-1:0] mx, my, yx, yy;
  logic [1:0]       sx, sy, s_hs, s_vs;
  btype_e           ty;
  logic             last;

  // Next-state: config latch on start, otherwise advance one block per pulse.
  always_comb begin
    width_d  = width_q;  height_d = height_q;
    mcus_x_d = mcus_x_q; mcus_y_d = mcus_y_q;
    mcu_x_d  = mcu_x_q;  mcu_y_d  = mcu_y_q;
    sub_x_d  = sub_x_q;  sub_y_d  = sub_y_q;
    hs_d     = hs_q;     vs_d     = vs_q;   mono_d = mono_q;
    bx_d     = bx_q;     by_d     = by_q;   type_d = type_q;
    valid_d  = valid_q;  eoi_d    = eoi_q;  ovf_d  = ovf_q;
    done_d   = 1'b0;
    mx = mcu_x_q; my = mcu_y_q; sx = sub_x_q; sy = sub_y_q; ty = type_q;
    last = 1'b0; yx = '0; yy = '0;
    s_hs = eff_samp(bus.img_hs_i, bus.img_mono_i);
    s_vs = eff_samp(bus.img_vs_i, bus.img_mono_i);

    if (bus.img_start_i) begin
      width_d  = bus.img_width_i;
      height_d = bus.img_height_i;
      mono_d   = bus.img_mono_i;
      hs_d     = s_hs;
      vs_d     = s_vs;
      mcus_x_d = mcu_cnt(bus.img_width_i, s_hs);
      mcus_y_d = mcu_cnt(bus.img_height_i, s_vs);
      mcu_x_d  = '0; mcu_y_d = '0; sub_x_d = '0; sub_y_d = '0;
      bx_d     = '0; by_d    = '0; type_d  = T_Y;
      valid_d  = 1'b1; eoi_d = 1'b0; ovf_d = 1'b0;
    end else if (bus.end_of_block_i) begin
      if (eoi_q) begin
        ovf_d = 1'b1;
      end else begin
        case (type_q)
          T_Y: begin
            if (sub_x_q + 2'd1 < hs_q) begin
              sx = sub_x_q + 2'd1;
            end else if (sub_y_q + 2'd1 < vs_q) begin
              sx = 2'd0;
              sy = sub_y_q + 2'd1;
            end else begin
              sx = 2'd0;
              sy = 2'd0;
              if (mono_q) last = 1'b1;
              else        ty   = T_CB;
            end
          end
          T_CB:    ty   = T_CR;
          default: last = 1'b1;
        endcase

        if (last) begin
          done_d = 1'b1;
          if (mcu_x_q == mcus_x_q - 1'b1 && mcu_y_q == mcus_y_q - 1'b1) begin
            eoi_d = 1'b1;
            ty    = T_EOF;
          end else begin
            ty = T_Y;
            if (mcu_x_q + 1'b1 == mcus_x_q) begin
              mx = '0;
              my = mcu_y_q + 1'b1;
            end else begin
              mx = mcu_x_q + 1'b1;
            end
          end
        end

        mcu_x_d = mx; mcu_y_d = my; sub_x_d = sx; sub_y_d = sy; type_d = ty;
        yx = mx * DIM_W'(hs_q) + DIM_W'(sx);
        yy = my * DIM_W'(vs_q) + DIM_W'(sy);
        // EOF keeps the coordinates and validity of the final block
        if (ty == T_Y) begin
          bx_d    = yx;
          by_d    = yy;
          valid_d = ((yx << 3) < width_q) && ((yy << 3) < height_q);
        end else if (ty != T_EOF) begin
          bx_d    = mx;
          by_d    = my;
          valid_d = 1'b1;
        end
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      width_q  <= '0;           height_q <= '0;
      mcus_x_q <= DIM_W'(1);    mcus_y_q <= DIM_W'(1);
      mcu_x_q  <= '0;           mcu_y_q  <= '0;
      sub_x_q  <= '0;           sub_y_q  <= '0;
      hs_q     <= 2'd1;         vs_q     <= 2'd1;
      mono_q   <= 1'b0;
      bx_q     <= '0;           by_q     <= '0;
      type_q   <= T_Y;
      valid_q  <= 1'b1;
      done_q   <= 1'b0;         eoi_q    <= 1'b0;   ovf_q <= 1'b0;
    end else begin
      width_q  <= width_d;      height_q <= height_d;
      mcus_x_q <= mcus_x_d;     mcus_y_q <= mcus_y_d;
      mcu_x_q  <= mcu_x_d;      mcu_y_q  <= mcu_y_d;
      sub_x_q  <= sub_x_d;      sub_y_q  <= sub_y_d;
      hs_q     <= hs_d;         vs_q     <= vs_d;
      mono_q   <= mono_d;
      bx_q     <= bx_d;         by_q     <= by_d;
      type_q   <= type_d;
      valid_q  <= valid_d;
      done_q   <= done_d;       eoi_q    <= eoi_d;  ovf_q <= ovf_d;
    end
  end

  assign bus.block_type_o   = type_q;
  assign bus.block_x_o      = bx_q;
  assign bus.block_y_o      = by_q;
  assign bus.block_id_o     = {type_q, by_q[DIM_W-3:0], bx_q};
  assign bus.block_valid_o  = valid_q;
  assign bus.mcu_done_o     = done_q;
  assign bus.end_of_image_o = eoi_q;
  assign bus.overflow_o     = ovf_q;

endmodule

// File: tb/tb_jpeg_mcu_seq.sv
// Bench for jpeg_mcu_seq: the model expands each image config into the full
// expected block list, then tracks a position in it cycle by cycle.
module tb_jpeg_mcu_seq;
  localparam int DIM_W = 16, MAX_SAMP = 2;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  jpeg_mcu_seq_if #(.DIM_W(DIM_W)) bus();
  jpeg_mcu_seq #(.DIM_W(DIM_W), .MAX_SAMP(MAX_SAMP)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct {int t; int x; int y; bit v; bit last;} blk_t;
  blk_t lst[$];
  int   idx = 0;
  bit   m_eoi = 0, m_ovf = 0, m_done = 0, chk_en = 0;
  int   total = 0, bad = 0, dcnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Full block list for an image, straight from the ordering rules.
  function automatic void build(int w, int h, bit mono, int hs, int vs);
    int ehs, evs, nmx, nmy, x, y;
    ehs = (mono || hs < 1 || hs > MAX_SAMP) ? 1 : hs;
    evs = (mono || vs < 1 || vs > MAX_SAMP) ? 1 : vs;
    nmx = (w == 0) ? 1 : (w + 8*ehs - 1) / (8*ehs);
    nmy = (h == 0) ? 1 : (h + 8*evs - 1) / (8*evs);
    lst.delete();
    for (int my = 0; my < nmy; my++)
      for (int mx = 0; mx < nmx; mx++) begin
        for (int sy = 0; sy < evs; sy++)
          for (int sx = 0; sx < ehs; sx++) begin
            x = mx*ehs + sx;
            y = my*evs + sy;
            lst.push_back('{0, x, y, (x*8 < w) && (y*8 < h), 1'b0});
          end
        if (!mono) begin
          lst.push_back('{1, mx, my, 1'b1, 1'b0});
          lst.push_back('{2, mx, my, 1'b1, 1'b0});
        end
        lst[lst.size()-1].last = 1'b1;
      end
  endfunction

  // Model advance on the same edge the DUT samples
  always @(posedge clk) begin
    if (rst) begin
      build(0, 0, 0, 1, 1); idx = 0; m_eoi = 0; m_ovf = 0; m_done = 0;
    end else if (bus.img_start_i) begin
      build(int'(bus.img_width_i), int'(bus.img_height_i), bus.img_mono_i,
            int'(bus.img_hs_i), int'(bus.img_vs_i));
      idx = 0; m_eoi = 0; m_ovf = 0; m_done = 0;
    end else if (bus.end_of_block_i) begin
      if (m_eoi) begin
        m_ovf = 1; m_done = 0;
      end else begin
        m_done = lst[idx].last;
        idx++;
        if (idx == lst.size()) m_eoi = 1;
      end
    end else begin
      m_done = 0;
    end
  end

  // Per-cycle compare against the model
  int k, et, ex, ey;
  bit ev;
  logic [31:0] eid;
  always @(negedge clk) if (chk_en) begin
    k  = m_eoi ? lst.size() - 1 : idx;
    et = m_eoi ? 3 : lst[k].t;
    ex = lst[k].x;
    ey = lst[k].y;
    ev = (k == 0) ? 1'b1 : lst[k].v;
    eid = {et[1:0], ey[DIM_W-3:0], ex[DIM_W-1:0]};
    chk("type",  bus.block_type_o, et);
    chk("x",     bus.block_x_o, ex[DIM_W-1:0]);
    chk("y",     bus.block_y_o, ey[DIM_W-1:0]);
    chk("valid", bus.block_valid_o, ev);
    chk("id",    bus.block_id_o, eid);
    chk("done",  bus.mcu_done_o, m_done);
    chk("eoi",   bus.end_of_image_o, m_eoi);
    chk("ovf",   bus.overflow_o, m_ovf);
    if (bus.mcu_done_o) dcnt++;
  end

  // Non-start cycles also scramble the config pins: only start may latch them.
  task automatic cyc(input bit s, input bit e, input bit r);
    @(negedge clk);
    bus.img_start_i = s; bus.end_of_block_i = e; rst = r;
    bus.img_width_i  = 16'($urandom_range(0, 200));
    bus.img_height_i = 16'($urandom_range(0, 200));
    bus.img_mono_i   = 1'($urandom_range(0, 1));
    bus.img_hs_i     = 2'($urandom_range(0, 3));
    bus.img_vs_i     = 2'($urandom_range(0, 3));
  endtask

  task automatic start_cfg(input int w, input int h, input bit mono,
                           input int hs, input int vs, input bit e);
    @(negedge clk);
    bus.img_start_i = 1; bus.end_of_block_i = e; rst = 0;
    bus.img_width_i = 16'(w); bus.img_height_i = 16'(h); bus.img_mono_i = mono;
    bus.img_hs_i = 2'(hs); bus.img_vs_i = 2'(vs);
    #1 dcnt = 0;
  endtask

  task automatic eobs(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0);
    cyc(0, 0, 0);
    #1;
  endtask

  int post;
  initial begin
    bus.img_start_i = 0; bus.end_of_block_i = 0; bus.img_width_i = '0;
    bus.img_height_i = '0; bus.img_mono_i = 0; bus.img_hs_i = '0; bus.img_vs_i = '0;
    @(negedge clk); @(negedge clk);
    chk_en = 1;
    cyc(0, 0, 0); #1;
    chk("rst_type", bus.block_type_o, 0);
    chk("rst_valid", bus.block_valid_o, 1);
    chk("rst_eoi", bus.end_of_image_o, 0);

    // mono 16x8
    start_cfg(16, 8, 1, 1, 1, 0);
    cyc(0, 0, 0); #1;
    chk("mono_len", lst.size(), 2);
    chk("mono_x1", lst[1].x, 1);
    eobs(2);
    chk("mono_eoi", bus.end_of_image_o, 1);
    chk("mono_type", bus.block_type_o, 3);
    chk("mono_dones", dcnt, 2);

    // 4:2:0 16x16
    start_cfg(16, 16, 0, 2, 2, 0);
    cyc(0, 0, 0); #1;
    chk("420_len", lst.size(), 6);
    chk("420_y3", {lst[3].t, lst[3].x, lst[3].y}, {32'd0, 32'd1, 32'd1});
    chk("420_cb", lst[4].t, 1);
    eobs(5);
    chk("420_cr", bus.block_type_o, 2);
    eobs(1);
    chk("420_eoi", bus.end_of_image_o, 1);
    chk("420_dones", dcnt, 1);

    // 4:2:2 24x8
    start_cfg(24, 8, 0, 2, 1, 0);
    cyc(0, 0, 0); #1;
    chk("422_len", lst.size(), 8);
    chk("422_pad", {lst[5].x, 31'd0, lst[5].v}, {32'd3, 32'd0});
    eobs(5);
    chk("422_x3", bus.block_x_o, 3);
    chk("422_v3", bus.block_valid_o, 0);
    eobs(1);
    chk("422_cbx", bus.block_x_o, 1);
    eobs(2);
    chk("422_eoi", bus.end_of_image_o, 1);

    // 4:4:4 8x8 with overflow, then restart
    start_cfg(8, 8, 0, 1, 1, 0);
    eobs(4);
    chk("444_eoi", bus.end_of_image_o, 1);
    chk("444_ovf", bus.overflow_o, 1);
    chk("444_type", bus.block_type_o, 3);
    start_cfg(8, 8, 0, 1, 1, 0);
    cyc(0, 0, 0); #1;
    chk("rs_ovf", bus.overflow_o, 0);
    chk("rs_type", bus.block_type_o, 0);

    // start wins over a simultaneous end_of_block, then reset mid-MCU
    start_cfg(16, 16, 0, 2, 2, 0);
    eobs(3);
    chk("mid_y", bus.block_y_o, 1);
    start_cfg(16, 16, 0, 2, 2, 1);
    cyc(0, 0, 0); #1;
    chk("se_x", bus.block_x_o, 0);
    chk("se_y", bus.block_y_o, 0);
    eobs(2);
    cyc(0, 0, 1);
    cyc(0, 0, 0); #1;
    chk("rm_x", bus.block_x_o, 0);
    chk("rm_valid", bus.block_valid_o, 1);

    // hs=3 clamps to 1
    start_cfg(8, 8, 0, 3, 1, 0);
    cyc(0, 0, 0); #1;
    chk("clamp_len", lst.size(), 3);
    eobs(3);
    chk("clamp_eoi", bus.end_of_image_o, 1);

    // random configs and pulse patterns
    for (int c = 0; c < 25; c++) begin
      start_cfg($urandom_range(0, 60), $urandom_range(0, 60), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3), 0);
      post = 0;
      for (int n = 0; n < 600 && post < 6; n++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 1)      cyc(0, 0, 1);
        else if (r < 3) start_cfg($urandom_range(0, 60), $urandom_range(0, 60),
                                  1'($urandom_range(0, 1)), $urandom_range(0, 3),
                                  $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        else            cyc(0, r < 75, 0);
        if (m_eoi) post++;
      end
    end
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
